// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: segment bit order, blank pattern, hex glyph table.
// Segments are active-low and packed as {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry h occupies bits [7h+6:7h]; listed from F down to 0.
  localparam logic [16*7-1:0] SEG_HEX_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {
    BLINK_VISIBLE = 1'b0,
    BLINK_HIDDEN  = 1'b1
  } blink_phase_t;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    return SEG_HEX_TABLE[{3'b000, hex} * 7 +: 7];
  endfunction

endpackage

// File: rtl/seg_scan_display_if.sv
// Load/display bundle between value producers and the scanned 7-segment driver.
// master = producer of values and consumer of pins; slave = the scanner itself.
interface seg_scan_display_if #(
  parameter int N_DIGITS = 4
);
  logic [4*N_DIGITS-1:0] digits_in;
  logic [N_DIGITS-1:0]   blank_in;
  logic [N_DIGITS-1:0]   dp_in;
  logic [N_DIGITS-1:0]   blink_in;
  logic                  load;
  logic                  pending;
  logic                  frame_done;
  logic [6:0]            leds;
  logic                  dp;
  logic [N_DIGITS-1:0]   Anode;

  modport master (
    output digits_in, blank_in, dp_in, blink_in, load,
    input  pending, frame_done, leds, dp, Anode
  );

  modport slave (
    input  digits_in, blank_in, dp_in, blink_in, load,
    output pending, frame_done, leds, dp, Anode
  );
endinterface

// File: rtl/seg_hex_decode.sv
// Combinational 4-bit hex to active-low 7-segment decoder.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  assign seg = hex_to_seg(hex);
endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed N-digit common-anode driver with guard interval, blink and
// double-buffered loads that only commit at frame boundaries.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 1,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                clk,
  input  logic                rst,
  seg_scan_display_if.slave   bus
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  typedef struct packed {
    logic [4*N_DIGITS-1:0] digits;
    logic [N_DIGITS-1:0]   blank;
    logic [N_DIGITS-1:0]   dp;
    logic [N_DIGITS-1:0]   blink;
  } disp_t;

  localparam disp_t DISP_RESET = '{digits: '0, blank: '1, dp: '0, blink: '0};

  logic [CW-1:0]       c_reg;
  logic [IW-1:0]       idx_reg;
  logic [BW-1:0]       blink_cnt_reg;
  blink_phase_t        phase_reg;
  disp_t               active_reg;
  disp_t               staged_reg;
  logic                pending_reg;
  logic                frame_done_reg;
  logic [N_DIGITS-1:0] anode_reg;
  logic [6:0]          leds_reg;
  logic                dp_reg;

  disp_t               load_value;
  logic                slot_end;
  logic                frame_end;
  logic [3:0]          cur_hex;
  logic                cur_blank;
  logic                cur_dp;
  logic                cur_blink;
  logic                lit;
  logic [6:0]          cur_seg;
  logic [N_DIGITS-1:0] anode_next;

  assign load_value = '{digits: bus.digits_in, blank: bus.blank_in,
                        dp: bus.dp_in, blink: bus.blink_in};
  assign slot_end   = (c_reg == CW'(REFRESH_DIV - 1));
  assign frame_end  = slot_end && (idx_reg == IW'(N_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      c_reg          <= '0;
      idx_reg        <= '0;
      blink_cnt_reg  <= '0;
      phase_reg      <= BLINK_VISIBLE;
      active_reg     <= DISP_RESET;
      staged_reg     <= DISP_RESET;
      pending_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= frame_end;
      if (slot_end) begin
        c_reg   <= '0;
        idx_reg <= (idx_reg == IW'(N_DIGITS - 1)) ? '0 : idx_reg + 1'b1;
      end else begin
        c_reg <= c_reg + 1'b1;
      end

      if (frame_end) begin
        if (blink_cnt_reg == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt_reg <= '0;
          phase_reg     <= (phase_reg == BLINK_VISIBLE) ? BLINK_HIDDEN : BLINK_VISIBLE;
        end else begin
          blink_cnt_reg <= blink_cnt_reg + 1'b1;
        end
      end

      // A load landing on the boundary bypasses the staging buffer entirely.
      if (bus.load && frame_end) begin
        active_reg  <= load_value;
        pending_reg <= 1'b0;
      end else if (bus.load) begin
        staged_reg  <= load_value;
        pending_reg <= 1'b1;
      end else if (frame_end && pending_reg) begin
        active_reg  <= staged_reg;
        pending_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    cur_hex   = '0;
    cur_blank = 1'b1;
    cur_dp    = 1'b0;
    cur_blink = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_reg == IW'(i)) begin
        cur_hex   = active_reg.digits[4*i +: 4];
        cur_blank = active_reg.blank[i];
        cur_dp    = active_reg.dp[i];
        cur_blink = active_reg.blink[i];
      end
    end
  end

  assign lit = (c_reg >= CW'(GUARD_CYCLES)) && !cur_blank &&
               !(cur_blink && (phase_reg == BLINK_HIDDEN));

  seg_hex_decode u_hex_decode (
    .hex (cur_hex),
    .seg (cur_seg)
  );

  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_anode
    assign anode_next[gi] = !(lit && (idx_reg == IW'(gi)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      anode_reg <= '1;
      leds_reg  <= SEG_BLANK;
      dp_reg    <= 1'b1;
    end else begin
      anode_reg <= anode_next;
      leds_reg  <= lit ? cur_seg : SEG_BLANK;
      dp_reg    <= lit ? ~cur_dp : 1'b1;
    end
  end

  assign bus.Anode      = anode_reg;
  assign bus.leds       = leds_reg;
  assign bus.dp         = dp_reg;
  assign bus.pending    = pending_reg;
  assign bus.frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display: directed scenarios plus random loads,
// compared each cycle against a frame/slot arithmetic reference model.
module tb_seg_scan_display;
  localparam int N     = 4;
  localparam int RD    = 4;
  localparam int GC    = 1;
  localparam int BF    = 2;
  localparam int FRAME = N * RD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_scan_display_if #(.N_DIGITS(N)) bus ();

  seg_scan_display #(
    .N_DIGITS     (N),
    .REFRESH_DIV  (RD),
    .GUARD_CYCLES (GC),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: cycles since reset, plus the displayed and staged values.
  int         k;
  logic [15:0] act_dig, pen_dig;
  logic [3:0]  act_blank, act_dp, act_blink;
  logic [3:0]  pen_blank, pen_dp, pen_blink;
  bit          pen;
  logic [6:0]  hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
    end
  endtask

  task automatic model_reset();
    k = 0;
    act_dig = '0; act_blank = 4'hF; act_dp = '0; act_blink = '0;
    pen_dig = '0; pen_blank = 4'hF; pen_dp = '0; pen_blink = '0;
    pen = 1'b0;
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    rst      = 1'b1;
    bus.load = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    chk("rst_anode", bus.Anode, 4'hF);
    chk("rst_leds", bus.leds, 7'h7F);
    chk("rst_dp", bus.dp, 1'b1);
    chk("rst_frame_done", bus.frame_done, 1'b0);
    chk("rst_pending", bus.pending, 1'b0);
    model_reset();
  endtask

  task automatic step(input bit ld, input logic [15:0] d, input logic [3:0] b,
                      input logic [3:0] p, input logic [3:0] bl);
    int c, idx, frames;
    bit hidden, lit, bnd;
    logic [3:0] e_anode;
    logic [6:0] e_leds;
    logic       e_dp;
    logic [3:0] nib;
    @(negedge clk);
    rst           = 1'b0;
    bus.load      = ld;
    bus.digits_in = d;
    bus.blank_in  = b;
    bus.dp_in     = p;
    bus.blink_in  = bl;
    c      = k % RD;
    idx    = (k / RD) % N;
    frames = k / FRAME;
    hidden = ((frames / BF) % 2) == 1;
    bnd    = (k % FRAME) == FRAME - 1;
    lit    = (c >= GC) && !act_blank[idx] && !(act_blink[idx] && hidden);
    nib    = act_dig[idx*4 +: 4];
    e_anode = 4'hF;
    e_leds  = 7'h7F;
    e_dp    = 1'b1;
    if (lit) begin
      e_anode[idx] = 1'b0;
      e_leds       = hex_tab[nib];
      e_dp         = ~act_dp[idx];
    end
    if (ld)
      $display("load k=%0d digits=%h blank=%b dp=%b blink=%b boundary=%0d",
               k, d, b, p, bl, bnd);
    if (ld && bnd) begin
      act_dig = d; act_blank = b; act_dp = p; act_blink = bl;
      pen = 1'b0;
    end else if (ld) begin
      pen_dig = d; pen_blank = b; pen_dp = p; pen_blink = bl;
      pen = 1'b1;
    end else if (bnd && pen) begin
      act_dig = pen_dig; act_blank = pen_blank; act_dp = pen_dp; act_blink = pen_blink;
      pen = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("anode", bus.Anode, e_anode);
    chk("leds", bus.leds, e_leds);
    chk("dp", bus.dp, e_dp);
    chk("frame_done", bus.frame_done, bnd);
    chk("pending", bus.pending, pen);
    k++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic advance_to(input int r);
    for (int i = 0; i < FRAME && (k % FRAME) != r; i++) idle(1);
  endtask

  initial begin
    bus.load      = 1'b0;
    bus.digits_in = '0;
    bus.blank_in  = '0;
    bus.dp_in     = '0;
    bus.blink_in  = '0;

    apply_reset(3);
    idle(40);

    step(1'b1, 16'hA5C3, 4'b0000, 4'b0100, 4'b0000);
    idle(40);

    advance_to(0);
    step(1'b1, 16'h1111, 4'b0000, 4'b0000, 4'b0000);
    idle(3);
    step(1'b1, 16'h2222, 4'b0000, 4'b0000, 4'b0000);
    idle(40);

    advance_to(FRAME - 1);
    step(1'b1, 16'h0007, 4'b0000, 4'b0000, 4'b0000);
    idle(20);

    step(1'b1, 16'h4328, 4'b0000, 4'b0010, 4'b0001);
    idle(6 * FRAME);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0)
        step(1'b1, 16'($urandom), 4'($urandom & $urandom), 4'($urandom), 4'($urandom));
      else
        idle(1);
    end

    advance_to(8);
    step(1'b1, 16'h9876, 4'b0000, 4'b1111, 4'b0000);
    apply_reset(1);
    idle(40);
    step(1'b1, 16'hBEEF, 4'b0000, 4'b0001, 4'b0000);
    idle(2 * FRAME);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
